// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data/parity/stop framing,
// 3-sample majority vote per bit, one-entry valid/ready output register.
module uart_rx_os #(
   parameter int CLK_DIV     = 130,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   input  logic                 overrun_clr,
   output logic                 busy
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int OW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
   } state_t;

   state_t state, state_d;

   logic [1:0]             rst_q;
   logic                   rst_n;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs, rxs_q;
   logic [DW-1:0]          div_cnt;
   logic [OW-1:0]          os_cnt;
   logic [3:0]             bit_cnt;
   logic [1:0]             smp;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit, perr, ferr;
   logic                   tick, vote_tick, bit_end, vote;
   logic                   last_data, last_stop, done, load;
   logic                   ferr_n, brk_n, par_exp;

   // Assert asynchronously, release on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_q <= '0;
      else          rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_n = rst_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;
         rxs_q <= 1'b1;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], rx};
         rxs_q <= rxs;
      end
   end
   assign rxs = sync[SYNC_STAGES-1];

   assign tick      = (div_cnt == DW'(CLK_DIV - 1));
   assign vote_tick = tick && (os_cnt == OW'(OVERSAMPLE/2 + 1));
   assign bit_end   = tick && (os_cnt == OW'(OVERSAMPLE - 1));
   assign vote      = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
   assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
   assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
   assign done      = (state == S_STOP) && vote_tick && last_stop;
   assign ferr_n    = ferr | ~vote;
   assign brk_n     = ~|shreg & ~par_bit & ferr_n;
   assign par_exp   = (PARITY == 2) ? ~^shreg : ^shreg;
   assign load      = done && (!valid || ready);
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:  if (rxs_q && !rxs) state_d = S_START;
         S_START: begin
            if (vote_tick && vote) state_d = S_IDLE;
            else if (bit_end)      state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end && last_data)
               state_d = (PARITY != 0) ? S_PAR : S_STOP;
         end
         S_PAR:   if (bit_end) state_d = S_STOP;
         S_STOP:  if (done) state_d = ferr_n ? S_WAIT : S_IDLE;
         S_WAIT:  if (rxs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Counters sit at zero while idle so bit phase follows the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         os_cnt  <= '0;
         bit_cnt <= '0;
         smp     <= '0;
      end else begin
         if (state == S_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
               os_cnt <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
         end
         if (state != state_d)
            bit_cnt <= '0;
         else if (bit_end && (state == S_DATA || state == S_STOP))
            bit_cnt <= bit_cnt + 1'b1;
         if (tick && os_cnt == OW'(OVERSAMPLE/2 - 1)) smp[0] <= rxs;
         if (tick && os_cnt == OW'(OVERSAMPLE/2))     smp[1] <= rxs;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         par_bit <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            par_bit <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
         end
         if (state == S_DATA && vote_tick)
            shreg <= {vote, shreg[DATA_BITS-1:1]};
         if (state == S_PAR && vote_tick) begin
            par_bit <= vote;
            perr    <= (vote != par_exp);
         end
         if (state == S_STOP && vote_tick)
            ferr <= ferr_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (load) begin
            data       <= shreg;
            parity_err <= perr;
            frame_err  <= ferr_n;
            break_det  <= brk_n;
            valid      <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         // A drop in the same cycle as a clear must still be reported.
         if (done && !load)  overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances (8N1, 8E1, 7O2),
// expected frames queued at send time and popped on each accept.
module tb_uart_rx_os;

   typedef struct {
      logic [8:0] d;
      logic       pe;
      logic       fe;
      logic       bk;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       rx_a, rx_b, rx_c;
   logic       ready_a, ready_b, ready_c;
   logic       clr_a, clr_b, clr_c;
   logic [7:0] data_a, data_b;
   logic [6:0] data_c;
   logic       valid_a, valid_b, valid_c;
   logic       pe_a, pe_b, pe_c;
   logic       fe_a, fe_b, fe_c;
   logic       bk_a, bk_b, bk_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic       busy_a, busy_b, busy_c;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int vectors = 0;
   int miscompares = 0;

   uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .data(data_a),
      .valid(valid_a), .ready(ready_a), .parity_err(pe_a),
      .frame_err(fe_a), .break_det(bk_a), .overrun(ovr_a),
      .overrun_clr(clr_a), .busy(busy_a));

   uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(rx_b), .data(data_b),
      .valid(valid_b), .ready(ready_b), .parity_err(pe_b),
      .frame_err(fe_b), .break_det(bk_b), .overrun(ovr_b),
      .overrun_clr(clr_b), .busy(busy_b));

   uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)) dut_c (
      .clk(clk), .reset_n(reset_n), .rx(rx_c), .data(data_c),
      .valid(valid_c), .ready(ready_c), .parity_err(pe_c),
      .frame_err(fe_c), .break_det(bk_c), .overrun(ovr_c),
      .overrun_clr(clr_c), .busy(busy_c));

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Reference: frame fields from plain bit counting.
   function automatic exp_t model(logic [8:0] d, int pm, logic pb,
                                  logic [1:0] st, int ns);
      exp_t e;
      int   ones;
      logic want;
      ones = $countones(d);
      if (pm == 1) want = (ones % 2 == 1);
      else         want = (ones % 2 == 0);
      e.d  = d;
      e.pe = (pm != 0) && (pb != want);
      e.fe = (st[0] == 1'b0) || (ns == 2 && st[1] == 1'b0);
      e.bk = (d == 9'd0) && (pm == 0 || pb == 1'b0) && e.fe;
      return e;
   endfunction

   function automatic logic good_par(logic [8:0] d, int pm);
      int ones;
      ones = $countones(d);
      return (pm == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
   endfunction

   task automatic push(int w, exp_t e);
      case (w)
         0: q_a.push_back(e);
         1: q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic set_rx(int w, logic v);
      case (w)
         0: rx_a = v;
         1: rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic send(int w, int nd, logic [8:0] d, int pm, logic pb,
                       logic [1:0] st, int ns, bit do_push);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < nd; i++) bits.push_back(d[i]);
      if (pm != 0) bits.push_back(pb);
      bits.push_back(st[0]);
      if (ns == 2) bits.push_back(st[1]);
      if (do_push) push(w, model(d, pm, pb, st, ns));
      @(posedge clk);
      #1;
      foreach (bits[i]) begin
         set_rx(w, bits[i]);
         repeat (64) @(posedge clk);
         #1;
      end
      set_rx(w, 1'b1);
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(int w, logic [8:0] d, logic pe, logic fe,
                          logic bk);
      exp_t e;
      int   n;
      n = (w == 0) ? q_a.size() : (w == 1) ? q_b.size() : q_c.size();
      if (n == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_%0d: got data %0h, want no frame", w, d);
         return;
      end
      case (w)
         0: e = q_a.pop_front();
         1: e = q_b.pop_front();
         default: e = q_c.pop_front();
      endcase
      chk($sformatf("data_%0d", w), 32'(d), 32'(e.d));
      chk($sformatf("parity_err_%0d", w), 32'(pe), 32'(e.pe));
      chk($sformatf("frame_err_%0d", w), 32'(fe), 32'(e.fe));
      chk($sformatf("break_det_%0d", w), 32'(bk), 32'(e.bk));
   endtask

   always @(negedge clk)
      if (valid_a && ready_a) pop_chk(0, {1'b0, data_a}, pe_a, fe_a, bk_a);
   always @(negedge clk)
      if (valid_b && ready_b) pop_chk(1, {1'b0, data_b}, pe_b, fe_b, bk_b);
   always @(negedge clk)
      if (valid_c && ready_c) pop_chk(2, {2'b0, data_c}, pe_c, fe_c, bk_c);

   task automatic pulse_ready_a();
      @(posedge clk);
      #1 ready_a = 1'b1;
      @(posedge clk);
      #1 ready_a = 1'b0;
   endtask

   initial begin
      logic [8:0] d;
      logic       pb;
      logic [1:0] st;
      reset_n = 1'b0;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(valid_a), 0);
      chk("reset_busy", 32'(busy_a), 0);
      chk("reset_overrun", 32'(ovr_a), 0);
      chk("reset_data", 32'(data_a), 0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // 0xA5 with ready low: latency, hold, release
      fork
         send(0, 8, 9'hA5, 0, 1'b0, 2'b11, 1, 1'b1);
         begin
            @(posedge clk);
            repeat (618) @(posedge clk);
            @(negedge clk);
            chk("latency_pre", 32'(valid_a), 0);
            @(negedge clk);
            chk("latency_post", 32'(valid_a), 1);
         end
      join
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(valid_a), 1);
      chk("hold_data", 32'(data_a), 32'hA5);
      chk("idle_busy", 32'(busy_a), 0);
      pulse_ready_a();
      @(negedge clk);
      chk("drop_valid", 32'(valid_a), 0);

      // even parity: good then flipped parity bit
      ready_b = 1'b1;
      send(1, 8, 9'h03, 1, 1'b0, 2'b11, 1, 1'b1);
      send(1, 8, 9'h03, 1, 1'b1, 2'b11, 1, 1'b1);

      // glitch shorter than half a bit
      ready_a = 1'b1;
      @(posedge clk);
      #1 rx_a = 1'b0;
      repeat (20) @(posedge clk);
      #1 rx_a = 1'b1;
      repeat (128) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy", 32'(busy_a), 0);
      send(0, 8, 9'h5A, 0, 1'b0, 2'b11, 1, 1'b1);

      // break: 12 bit times low
      push(0, model(9'h000, 0, 1'b0, 2'b00, 1));
      @(posedge clk);
      #1 rx_a = 1'b0;
      repeat (11 * 64) @(posedge clk);
      #1;
      chk("break_wait_busy", 32'(busy_a), 1);
      repeat (64) @(posedge clk);
      #1 rx_a = 1'b1;
      repeat (64) @(posedge clk);
      @(negedge clk);
      chk("break_end_busy", 32'(busy_a), 0);
      send(0, 8, 9'h96, 0, 1'b0, 2'b11, 1, 1'b1);

      // overrun with ready low, then clear
      ready_a = 1'b0;
      send(0, 8, 9'h11, 0, 1'b0, 2'b11, 1, 1'b1);
      send(0, 8, 9'h22, 0, 1'b0, 2'b11, 1, 1'b0);
      @(negedge clk);
      chk("ovr_valid", 32'(valid_a), 1);
      chk("ovr_data", 32'(data_a), 32'h11);
      chk("ovr_set", 32'(ovr_a), 1);
      @(posedge clk);
      #1 clr_a = 1'b1;
      @(posedge clk);
      #1 clr_a = 1'b0;
      @(negedge clk);
      chk("ovr_clr", 32'(ovr_a), 0);
      pulse_ready_a();

      // accept on the delivery cycle: no overrun
      send(0, 8, 9'h11, 0, 1'b0, 2'b11, 1, 1'b1);
      fork
         send(0, 8, 9'h22, 0, 1'b0, 2'b11, 1, 1'b1);
         begin
            @(posedge clk);
            repeat (618) @(posedge clk);
            #1 ready_a = 1'b1;
            @(posedge clk);
            #1 ready_a = 1'b0;
         end
      join
      @(negedge clk);
      chk("same_cycle_ovr", 32'(ovr_a), 0);
      chk("same_cycle_valid", 32'(valid_a), 1);
      chk("same_cycle_data", 32'(data_a), 32'h22);
      pulse_ready_a();

      // randomized frames on all three configurations
      ready_a = 1'b1;
      ready_c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = 9'($urandom_range(0, 255));
         send(0, 8, d, 0, 1'b0, 2'b11, 1, 1'b1);
         d = 9'($urandom_range(0, 255));
         pb = good_par(d, 1) ^ 1'($urandom_range(0, 1));
         st = {1'b1, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1};
         send(1, 8, d, 1, pb, st, 1, 1'b1);
         d = 9'($urandom_range(0, 127));
         pb = good_par(d, 2) ^ 1'($urandom_range(0, 1));
         st = 2'($urandom_range(0, 3));
         send(2, 7, d, 2, pb, st, 2, 1'b1);
      end
      send(2, 7, 9'h000, 2, 1'b0, 2'b00, 2, 1'b1);

      // reset in the middle of a 7O2 frame
      repeat (20) @(posedge clk);
      #1 rx_c = 1'b0;
      repeat (64) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #1 rx_c = 1'(8'h3C >> i);
         repeat (64) @(posedge clk);
      end
      #1 reset_n = 1'b0;
      rx_c = 1'b1;
      #1;
      chk("midreset_valid", 32'(valid_c), 0);
      chk("midreset_busy", 32'(busy_c), 0);
      chk("midreset_data", 32'(data_c), 0);
      repeat (10) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5 * 64) @(posedge clk);
      @(negedge clk);
      chk("postreset_busy", 32'(busy_c), 0);
      chk("postreset_valid", 32'(valid_c), 0);
      send(2, 7, 9'h03C, 2, good_par(9'h03C, 2), 2'b11, 2, 1'b1);
      send(2, 7, 9'h03C, 2, good_par(9'h03C, 2), 2'b01, 2, 1'b1);

      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("left_a", 32'(q_a.size()), 0);
      chk("left_b", 32'(q_b.size()), 0);
      chk("left_c", 32'(q_c.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. It replaces the fixed 8N1 baud-edge receiver used for control-computer links. Data width, parity mode and stop-bit count are configurable. Each bit is taken as a 3-sample majority vote at mid-bit, and the block reports parity, framing, break and overrun conditions. Received frames are presented on a valid/ready output held in a one-entry register, for the command decoder to consume.

Parameters:
CLK_DIV, 130, clk cycles per oversample tick (20 MHz / (9600*16)); range >= 2
OVERSAMPLE, 16, ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, rx synchroniser depth; >= 2

Ports:
clk  in  1  module clock
reset_n  in  1  asynchronous, active-low reset
rx  in  1  UART line, idle high, asynchronous to clk
data  out  DATA_BITS  received word, LSB = first data bit
valid  out  1  data and flags are valid; held until accepted
ready  in  1  consumer accepts when valid & ready
parity_err  out  1  parity mismatch for the presented word; qualified by valid
frame_err  out  1  a stop bit sampled 0; qualified by valid
break_det  out  1  all data bits 0, parity bit 0 if present, and frame_err; qualified by valid
overrun  out  1  sticky: a frame was dropped because valid & !ready
overrun_clr  in  1  synchronous clear of overrun
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; synchroniser flops = 1.
  - Counters = 0.
  - All outputs = 0.
  - A frame in progress is aborted and never presented.
- rx synchronised through SYNC_STAGES flops. All logic uses the synchronised value rxs.
- Tick generator:
  - div_cnt counts 0..CLK_DIV-1; tick = (div_cnt == CLK_DIV-1).
  - Held at 0 in IDLE, so bit phase is aligned to the start edge.
- Bit timing:
  - os_cnt counts ticks 0..OVERSAMPLE-1 within each bit.
  - Samples taken at os_cnt = OS/2-1, OS/2 and OS/2+1.
  - The bit value is the majority of the 3 samples, decided on the tick where os_cnt = OS/2+1 ("vote tick").
  - The next bit starts after the tick where os_cnt = OS-1.
- FSM:
  - IDLE: rxs falling (previous 1, now 0) -> START. busy = 1.
  - START: vote = 1 -> IDLE (false start, no output). vote = 0 -> DATA at bit end.
  - DATA: shift voted bits in LSB-first. After DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  - PARITY: expected bit = ^data (even) or ~^data (odd). perr = (vote != expected).
  - STOP: ferr |= (vote == 0) for each stop bit. On the vote tick of the last stop bit, the frame completes (no wait for bit end). Next state: IDLE if ferr = 0, else WAIT_HIGH.
  - WAIT_HIGH: stay until rxs = 1, then IDLE. This prevents a line break from retriggering.
- Delivery (on the clock after the completing vote tick):
  - If !valid, or valid & ready in that cycle: load data/flags and set valid = 1.
  - Otherwise: drop the frame; keep the old data/flags; set overrun = 1.
  - Latency: valid rises 1 clk after the final stop-bit vote tick.
- Output register:
  - Cleared by valid & ready with no simultaneous load; valid -> 0 next cycle.
  - data and flags are stable while valid = 1.
  - valid does not depend combinationally on ready.
- overrun:
  - Cleared by overrun_clr.
  - If a set and overrun_clr occur in the same cycle, set wins.
- Error and break handling:
  - parity_err and frame_err do not suppress delivery.
  - break_det implies frame_err.

Test Plan:
- Simulation settings for all scenarios: CLK_DIV = 4, OVERSAMPLE = 16, i.e. 64 clk per bit.
- 8N1, send 0xA5, ready = 0 -> valid rises 1 clk after the stop vote tick, data = 0xA5, all flags 0. valid holds until ready = 1, then drops the next clk. busy returns to 0.
- PARITY = 1, send 0x03 with parity bit 0 -> parity_err = 0. Resend with parity bit 1 -> data = 0x03, parity_err = 1, valid = 1.
- Glitch: rx low for 20 clk (< half bit) -> no valid; FSM back in IDLE. A following 0x5A frame is received correctly.
- Break: rx low for 12 bit times -> exactly one valid with data = 0x00, frame_err = 1, break_det = 1. No further frame until rx is high; a frame after that is received normally.
- Overrun, ready = 0: send 0x11 then 0x22 -> data = 0x11, overrun = 1. Pulse overrun_clr -> overrun = 0. Repeat with ready = 1 on the delivery cycle of 0x22 -> data = 0x22, overrun = 0.
- Reset mid-frame: DATA_BITS = 7, PARITY = 2, STOP_BITS = 2; reset_n low after 4 data bits -> outputs 0 immediately, no valid. A subsequent 0x3C frame with correct odd parity gives data = 0x3C, no errors. A second stop bit of 0 gives frame_err = 1.
